ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes EX-stage operands (forwarded Qa/Qb) plus a mul/div opcode, and computes the 64-bit product or the quotient/remainder into architectural HI/LO registers.
- Its busy output drives the stall2 input of the ID/EX register and the upstream IF/ID hold logic, freezing the front end while it iterates.

Parameters:
- DATA_W, 32, operand and HI/LO width; only 32 is supported and verified.
- CNT_W, 5, iteration counter width; must equal log2(DATA_W).

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  launch the operation in op; sampled only in IDLE
op  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
a  input  32  EX Qa after forwarding (multiplicand / dividend)
b  input  32  EX Qb after forwarding (multiplier / divisor)
hi_we  input  1  MTHI write strobe
lo_we  input  1  MTLO write strobe
wdata  input  32  MTHI/MTLO data
busy  output  1  stall request to ID/EX (stall2) and PC/IF-ID
done  output  1  one-cycle pulse when HI/LO commit
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Clock is clock. Reset is synchronous and active-high, sampled on the rising edge.
- Reset forces state=IDLE, hi=0, lo=0, done=0, counter=0 and all internal accumulators to 0. Reset mid-operation abandons the operation; no partial result is written.
- busy = start | (state != IDLE). This is combinational, so the pipeline stalls in the same cycle start is presented.
- States:
  - IDLE: at edge E0 with start=1, latch |a| and |b| (absolute values for signed ops, raw for unsigned), latch the sign flags, set counter=0, and go to MUL (op 0/1) or DIV (op 2/3).
  - MUL: one shift-add step per edge over the 64-bit accumulator. After the 32nd step (edge E32) go to FIXUP.
  - DIV: one restoring step per edge. Shift {rem,quo} left; if rem >= divisor, subtract and set the quotient bit. After the 32nd step (E32) go to FIXUP.
  - FIXUP: at E33, apply sign correction, write HI/LO, drive done=1 for the following cycle, and go to IDLE.
- Latency: busy is high for 34 cycles, from the start cycle through the FIXUP cycle. The result is visible on hi/lo in the cycle after E33.
- MULT/MULTU result: {hi,lo} = 64-bit product. For MULT, negate the 64-bit magnitude product when sign(a) != sign(b).
- DIV/DIVU result: lo = quotient, hi = remainder. For signed ops, the quotient is negated when the signs differ; the remainder takes the sign of the dividend.
- Divide by zero (b=0, DIV or DIVU): hi = a (unmodified), lo = 0xFFFFFFFF. No exception is raised and latency is unchanged.
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo = 0x80000000, hi = 0.
- start while state != IDLE is ignored; the stalled pipeline holds start high, and that is harmless.
- hi_we/lo_we are honoured only in IDLE with start=0. If start=1 in the same cycle, start wins and the writes are dropped. Writes while busy are dropped.
- hi_we and lo_we both high writes wdata to both registers.
- hi and lo hold their value between commits; they are never written mid-operation.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU compute the product combinationally from the latched operands. IDLE goes straight to FIXUP at E0, commit happens at E1, and busy lasts 2 cycles. DIV/DIVU are unchanged.
- Undefined: the iterative 34-cycle multiplier is used, and no hardware multiplier is inferred.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - the state encoding IDLE/MUL/DIV/FIXUP;
  - DATA_W;
  - the divide-by-zero quotient constant 0xFFFFFFFF.
- One sub-module, muldiv_div_step: a combinational single restoring-divide iteration. Inputs are rem, quo and divisor; outputs are next rem and next quo.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy 34 cycles, done pulse, hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=100, b=0 -> hi=100, lo=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Corner combinations:
  - MTHI wdata=0x1234 with start in the same cycle -> write dropped, operation runs.
  - Reset asserted at cycle 10 of a DIV -> busy=0, hi=lo=0 and done=0 next cycle.
  - MULDIV_FAST_MUL_EN build: MULT 6x7 -> busy 2 cycles, lo=42.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op and state
// encodings, datapath widths, the divide-by-zero quotient and an abs helper.
package muldiv_pkg;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 5;

   typedef enum logic [1:0] {
      OP_MULT  = 2'd0,
      OP_MULTU = 2'd1,
      OP_DIV   = 2'd2,
      OP_DIVU  = 2'd3
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MUL   = 2'd1,
      DIV   = 2'd2,
      FIXUP = 2'd3
   } muldiv_state_e;

   // Quotient reported for any divide by zero.
   localparam logic [DATA_W-1:0] DIV_ZERO_QUO = '1;

   // Magnitude of an operand; unsigned ops pass the raw value through.
   function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x,
                                                 input logic is_signed);
      return (is_signed && x[DATA_W-1]) ? -x : x;
   endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Operand/result bundle between the EX stage and the mul/div unit.
// Handshake: the EX stage raises start with op/a/b valid; busy goes high in
// the same cycle and stays high until the result is committed, so busy is
// the "not ready" indication and start is only accepted while the unit is
// idle. done pulses for one cycle when hi/lo take the new result.
interface ex_muldiv_unit_if;
   import muldiv_pkg::*;

   logic                start;
   logic [1:0]          op;
   logic [DATA_W-1:0]   a;
   logic [DATA_W-1:0]   b;
   logic                hi_we;
   logic                lo_we;
   logic [DATA_W-1:0]   wdata;
   logic                busy;
   logic                done;
   logic [DATA_W-1:0]   hi;
   logic [DATA_W-1:0]   lo;
   muldiv_state_e       state_dbg;

   modport master (
      output start, op, a, b, hi_we, lo_we, wdata,
      input  busy, done, hi, lo, state_dbg
   );

   modport slave (
      input  start, op, a, b, hi_we, lo_we, wdata,
      output busy, done, hi, lo, state_dbg
   );

endinterface

// File: rtl/muldiv_div_step.sv
// One restoring-divide iteration: shift {rem,quo} left by one, and if the
// shifted remainder covers the divisor, subtract it and set the quotient bit.
module muldiv_div_step
   import muldiv_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic [W-1:0] rem,
   input  logic [W-1:0] quo,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_next,
   output logic [W-1:0] quo_next
);

   logic [W:0] rem_sh;

   // Trial subtraction; the true difference always fits in W bits because
   // the incoming remainder is strictly below the divisor.
   always_comb begin
      rem_sh = {rem, quo[W-1]};
      if (rem_sh >= {1'b0, divisor}) begin
         rem_next = rem_sh[W-1:0] - divisor;
         quo_next = {quo[W-2:0], 1'b1};
      end else begin
         rem_next = rem_sh[W-1:0];
         quo_next = {quo[W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multi-cycle multiply/divide unit with architectural HI/LO.
// Iterative shift-add multiply and restoring divide share one 64-bit
// accumulator: upper half = partial product / remainder, lower half =
// multiplier / quotient. Defining MULDIV_FAST_MUL_EN replaces the iterative
// multiply with a single-cycle combinational product.
module ex_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int DATA_W = muldiv_pkg::DATA_W,
   parameter int CNT_W  = muldiv_pkg::CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   ex_muldiv_unit_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   muldiv_state_e       state;
   muldiv_state_e       state_next;
   logic [CNT_W-1:0]    cnt;
   logic [2*DATA_W-1:0] acc;
   logic [DATA_W-1:0]   opnd;      // multiplicand magnitude or divisor magnitude
   logic [DATA_W-1:0]   a_raw;     // dividend as presented, for divide by zero
   logic                neg_res;
   logic                neg_rem;
   logic                div_zero;
   logic                is_div_q;
   logic [DATA_W-1:0]   hi_q;
   logic [DATA_W-1:0]   lo_q;
   logic                done_q;

   logic                is_signed;
   logic                is_div;
   logic                last_step;
   logic [DATA_W:0]     mul_sum;
   logic [2*DATA_W-1:0] mul_next;
   logic [2*DATA_W-1:0] product;
   logic [2*DATA_W-1:0] prod_fix;
   logic [DATA_W-1:0]   quo_fix;
   logic [DATA_W-1:0]   rem_fix;
   logic [DATA_W-1:0]   rem_next;
   logic [DATA_W-1:0]   quo_next;

   assign is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
   assign is_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
   assign last_step = (cnt == CNT_LAST);

   muldiv_div_step #(.W(DATA_W)) u_div_step (
      .rem      (acc[2*DATA_W-1:DATA_W]),
      .quo      (acc[DATA_W-1:0]),
      .divisor  (opnd),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

   // Multiply step, final product selection and sign correction.
   always_comb begin
      mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
      mul_next = {mul_sum, acc[DATA_W-1:1]};
`ifdef MULDIV_FAST_MUL_EN
      product  = {{DATA_W{1'b0}}, opnd} * {{DATA_W{1'b0}}, acc[DATA_W-1:0]};
`else
      product  = acc;
`endif
      prod_fix = neg_res ? -product : product;
      quo_fix  = neg_res ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
      rem_fix  = neg_rem ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic: launch from IDLE, iterate, one fixup cycle, back to IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               if (is_div) begin
                  state_next = DIV;
               end else begin
`ifdef MULDIV_FAST_MUL_EN
                  state_next = FIXUP;
`else
                  state_next = MUL;
`endif
               end
            end
         end
         MUL, DIV: if (last_step) state_next = FIXUP;
         FIXUP:    state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // Outputs: busy asserts combinationally with start so the front end stalls at once.
   always_comb begin
      bus.busy      = bus.start | (state != IDLE);
      bus.state_dbg = state;
   end

   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

   // Datapath: operand latch, iteration, commit, and MTHI/MTLO writes in IDLE.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt      <= '0;
         acc      <= '0;
         opnd     <= '0;
         a_raw    <= '0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         is_div_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  // start takes priority; any HI/LO write this cycle is dropped
                  acc      <= {{DATA_W{1'b0}}, is_div ? abs_val(bus.a, is_signed)
                                                      : abs_val(bus.b, is_signed)};
                  opnd     <= is_div ? abs_val(bus.b, is_signed) : abs_val(bus.a, is_signed);
                  a_raw    <= bus.a;
                  neg_res  <= is_signed & (bus.a[DATA_W-1] ^ bus.b[DATA_W-1]);
                  neg_rem  <= is_signed & bus.a[DATA_W-1];
                  div_zero <= is_div & (bus.b == '0);
                  is_div_q <= is_div;
                  cnt      <= '0;
               end else begin
                  if (bus.hi_we) hi_q <= bus.wdata;
                  if (bus.lo_we) lo_q <= bus.wdata;
               end
            end
            MUL: begin
               acc <= mul_next;
               cnt <= cnt + CNT_W'(1);
            end
            DIV: begin
               acc <= {rem_next, quo_next};
               cnt <= cnt + CNT_W'(1);
            end
            FIXUP: begin
               if (is_div_q) begin
                  if (div_zero) begin
                     hi_q <= a_raw;
                     lo_q <= DIV_ZERO_QUO;
                  end else begin
                     hi_q <= rem_fix;
                     lo_q <= quo_fix;
                  end
               end else begin
                  hi_q <= prod_fix[2*DATA_W-1:DATA_W];
                  lo_q <= prod_fix[DATA_W-1:0];
               end
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: vector table of mul/div operations with
// hand-computed HI/LO results, plus MTHI/MTLO and reset-abort sequences.
module tb_ex_muldiv_unit;
   import muldiv_pkg::*;

   logic clock;
   logic reset;
   int   n_checks;
   int   n_pass;
   logic [63:0] exp_q[$];

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;   // {hi, lo}
      string       name;
   } vec_t;

   vec_t vecs[12];

   ex_muldiv_unit_if bus();

   ex_muldiv_unit dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Clock and watchdog.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int exp_lat(input logic [1:0] op);
`ifdef MULDIV_FAST_MUL_EN
      return op[1] ? 34 : 2;
`else
      return 34;
`endif
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Launch one operation, measure busy length, then check the committed result.
   task automatic run_op(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                         input string name, input bit mthi_with_start, input bit mtlo_mid);
      int          cyc;
      bit          seen;
      logic [31:0] hi_before;
      logic [31:0] lo_before;
      logic [63:0] exp_v;
      @(negedge clock);
      hi_before = bus.hi;
      lo_before = bus.lo;
      bus.start = 1'b1;
      bus.op    = op_i;
      bus.a     = a_i;
      bus.b     = b_i;
      if (mthi_with_start) begin
         bus.hi_we = 1'b1;
         bus.wdata = 32'h0000_1234;
      end
      #1;
      check({name, " busy_at_start"}, 64'(bus.busy), 64'd1);
      cyc = 1;
      @(posedge clock);
      #1;
      check({name, " hi_hold_after_launch"}, 64'(bus.hi), 64'(hi_before));
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clock);
         if (bus.busy) cyc++;
         else seen = 1'b1;
         if (mtlo_mid && i == 4) begin
            check({name, " lo_hold_while_busy"}, 64'(bus.lo), 64'(lo_before));
            bus.lo_we = 1'b0;
         end
         if (mtlo_mid && i == 3) begin
            bus.lo_we = 1'b1;
            bus.wdata = 32'h0000_DEAD;
         end
      end
      bus.lo_we = 1'b0;
      check({name, " completed"}, 64'(seen), 64'd1);
      check({name, " busy_cycles"}, 64'(cyc), 64'(exp_lat(op_i)));
      check({name, " done_pulse"}, 64'(bus.done), 64'd1);
      if (exp_q.size() == 0) begin
         check({name, " scoreboard_has_entry"}, 64'(exp_q.size()), 64'd1);
      end else begin
         exp_v = exp_q.pop_front();
         check({name, " hi"}, 64'(bus.hi), 64'(exp_v[63:32]));
         check({name, " lo"}, 64'(bus.lo), 64'(exp_v[31:0]));
      end
      @(negedge clock);
      check({name, " done_one_cycle"}, 64'(bus.done), 64'd0);
   endtask

   task automatic mt_write(input bit hwe, input bit lwe, input logic [31:0] d);
      @(negedge clock);
      bus.hi_we = hwe;
      bus.lo_we = lwe;
      bus.wdata = d;
      @(negedge clock);
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
   endtask

   initial begin
      int dones;
      n_checks = 0;
      n_pass   = 0;
      vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max"};
      vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, "mult_neg3x7"};
      vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, "div_neg7by2"};
      vecs[3]  = '{OP_DIVU,  32'h0000_0064, 32'h0000_0000, 64'h0000_0064_FFFF_FFFF, "divu_by_zero"};
      vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_overflow"};
      vecs[5]  = '{OP_MULT,  32'h0000_0006, 32'h0000_0007, 64'h0000_0000_0000_002A, "mult_6x7"};
      vecs[6]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 64'h0000_000F_0FFF_FFFF, "divu_max_by16"};
      vecs[7]  = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, "div_7byneg2"};
      vecs[8]  = '{OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 64'hFFFF_FFFB_FFFF_FFFF, "div_neg_by_zero"};
      vecs[9]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "mult_min_sq"};
      vecs[10] = '{OP_MULTU, 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780, "multu_shift"};
      vecs[11] = '{OP_MULT,  32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, "mult_neg1x1"};

      reset     = 1'b1;
      bus.start = 1'b0;
      bus.op    = 2'd0;
      bus.a     = '0;
      bus.b     = '0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      bus.wdata = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      check("reset busy", 64'(bus.busy), 64'd0);
      check("reset done", 64'(bus.done), 64'd0);
      check("reset hi", 64'(bus.hi), 64'd0);
      check("reset lo", 64'(bus.lo), 64'd0);
      check("reset state", 64'(bus.state_dbg), 64'(IDLE));

      // Table of operations.
      for (int i = 0; i < 12; i++) begin
         exp_q.push_back(vecs[i].exp);
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].name, 1'b0, 1'b0);
      end

      // MTHI, MTLO, and both together while idle.
      mt_write(1'b1, 1'b0, 32'hCAFE_0001);
      check("mthi hi", 64'(bus.hi), 64'h0000_0000_CAFE_0001);
      mt_write(1'b0, 1'b1, 32'h0BAD_F00D);
      check("mtlo lo", 64'(bus.lo), 64'h0000_0000_0BAD_F00D);
      check("mtlo hi_untouched", 64'(bus.hi), 64'h0000_0000_CAFE_0001);
      mt_write(1'b1, 1'b1, 32'h0000_1111);
      check("mt_both hi", 64'(bus.hi), 64'h0000_0000_0000_1111);
      check("mt_both lo", 64'(bus.lo), 64'h0000_0000_0000_1111);

      // MTHI alongside start is dropped; MTLO while busy is dropped.
      exp_q.push_back(64'h0000_0000_0000_000F);
      run_op(OP_MULTU, 32'd3, 32'd5, "mthi_with_start", 1'b1, 1'b1);

      // Reset at cycle 10 of a divide abandons it with no commit.
      @(negedge clock);
      bus.start = 1'b1;
      bus.op    = OP_DIVU;
      bus.a     = 32'd1000;
      bus.b     = 32'd7;
      @(negedge clock);
      bus.start = 1'b0;
      repeat (9) @(negedge clock);
      check("abort busy_before_reset", 64'(bus.busy), 64'd1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("abort busy", 64'(bus.busy), 64'd0);
      check("abort done", 64'(bus.done), 64'd0);
      check("abort hi", 64'(bus.hi), 64'd0);
      check("abort lo", 64'(bus.lo), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      dones = 0;
      repeat (40) begin
         @(negedge clock);
         if (bus.done) dones++;
      end
      check("abort no_late_done", 64'(dones), 64'd0);
      check("abort lo_after", 64'(bus.lo), 64'd0);

      // Normal operation resumes after the abort.
      exp_q.push_back(64'h0000_0006_0000_008E);
      run_op(OP_DIVU, 32'd1000, 32'd7, "divu_after_abort", 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
